// File: rtl/sram_if_pkg.sv
// Shared constants and FSM encoding for the SRAM burst reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sram_if_pkg;

    localparam int AW_DEF = 10;
    localparam int DW_DEF = 128;

    // Width of a beat counter that must hold 2^aw (a full-memory burst).
    function automatic int beat_cnt_w(input int aw);
        return aw + 1;
    endfunction

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_ABORT = 2'd3;

endpackage

// File: rtl/sram_burst_reader_if.sv
// Bundle of command, SRAM and read-stream signals of the burst reader.
// Latency: n/a (wiring only).
// Backpressure: rd_valid/rd_ready stream, cmd_valid/cmd_ready command.
// master: the reader side; slave: the command source, SRAM and consumer side.
interface sram_burst_reader_if #(
    parameter int AW     = sram_if_pkg::AW_DEF,
    parameter int DW     = sram_if_pkg::DW_DEF,
    parameter int STRB_W = DW / 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [AW-1:0]     cmd_addr;
    logic [AW-1:0]     cmd_len;
    logic              abort;
    logic              sram_cen;
    logic              sram_wen;
    logic [AW-1:0]     sram_addr;
    logic [DW-1:0]     sram_wdata;
    logic [STRB_W-1:0] sram_wstrb;
    logic [DW-1:0]     sram_rdata;
    logic              rd_valid;
    logic              rd_ready;
    logic [DW-1:0]     rd_data;
    logic              rd_last;
    logic              busy;
    logic              done;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, abort, sram_rdata, rd_ready,
        output cmd_ready, sram_cen, sram_wen, sram_addr, sram_wdata, sram_wstrb,
               rd_valid, rd_data, rd_last, busy, done
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, abort, sram_rdata, rd_ready,
        input  cmd_ready, sram_cen, sram_wen, sram_addr, sram_wdata, sram_wstrb,
               rd_valid, rd_data, rd_last, busy, done
    );
endinterface

// File: rtl/sync_fifo_flag.sv
// Register FIFO of W-bit entries (typically {last, data}) with synchronous flush.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push ignored when full unless a pop happens the same cycle.
// Ports: clk, rst_n, flush, push/push_dat, pop, head_dat, count, empty.
module sync_fifo_flag #(
    parameter int DEPTH = 2,
    parameter int W     = 129,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic [CW-1:0] count,
    output logic          empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A full FIFO may still accept a push when the head leaves in the same cycle.
    assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/sram_burst_reader.sv
// Burst read initiator: turns {addr, len} commands into one SRAM read per cycle.
// Latency: first rd_valid two cycles after command accept; one beat per cycle sustained.
// Backpressure: issue is credit-limited so fifo_count + inflight never exceeds FIFO_DEPTH.
// Ports: clk, rst_n (async, active-low), bus (master modport: command, SRAM, stream, status).
module sram_burst_reader
    import sram_if_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int STRB_W     = DW / 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sram_burst_reader_if.master  bus
);
    localparam int CW  = beat_cnt_w(AW);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   cur_addr;
    logic [CW-1:0]   remain;
    logic            inflight;
    logic            inflight_last;
    logic [FCW-1:0]  fifo_count;
    logic            fifo_empty;
    logic [DW:0]     fifo_head;
    logic            in_burst;
    logic            abort_hit;
    logic            accept;
    logic            rd_vld;
    logic            pop;
    logic            bypass;
    logic            issue;
    logic            last_issue;
    logic            finish;
    logic            fifo_push;
    logic            fifo_pop;

    assign in_burst  = (state == ST_RUN) || (state == ST_DRAIN);
    assign abort_hit = in_burst && bus.abort;
    assign accept    = (state == ST_IDLE) && bus.cmd_valid;

    // With an empty FIFO the returning SRAM word is presented directly, which
    // gives the two-cycle first-beat latency and lets a depth-2 FIFO sustain
    // one beat per cycle.
    assign bypass = fifo_empty && inflight;
    assign rd_vld = !fifo_empty || inflight;
    assign pop    = rd_vld && bus.rd_ready;

    assign issue = (state == ST_RUN) && !bus.abort && (remain != '0) &&
                   ((int'(fifo_count) + int'(inflight) - int'(pop)) < FIFO_DEPTH);
    assign last_issue = issue && (remain == CW'(1));

    // Returning data goes to the FIFO unless it was consumed via the bypass
    // path or the burst is being aborted this cycle.
    assign fifo_push = inflight && !abort_hit && !(bypass && pop);
    assign fifo_pop  = pop && !fifo_empty && !abort_hit;

    // An empty FIFO with nothing in flight in DRAIN means the last beat has left.
    assign finish = ((state == ST_DRAIN) && !bus.abort && fifo_empty && !inflight) ||
                    ((state == ST_ABORT) && !inflight);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_RUN;
            ST_RUN: begin
                if (bus.abort)       state_nxt = ST_ABORT;
                else if (last_issue) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (bus.abort)       state_nxt = ST_ABORT;
                else if (finish)     state_nxt = ST_IDLE;
            end
            ST_ABORT: if (finish) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cur_addr      <= '0;
            remain        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            state         <= state_nxt;
            inflight      <= issue;
            inflight_last <= last_issue;
            if (accept) begin
                cur_addr <= bus.cmd_addr;
                remain   <= CW'(bus.cmd_len) + CW'(1);
            end else if (issue) begin
                cur_addr <= cur_addr + AW'(1);
                remain   <= remain - CW'(1);
            end
        end
    end

    sync_fifo_flag #(
        .DEPTH (FIFO_DEPTH),
        .W     (DW + 1),
        .CW    (FCW)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (abort_hit),
        .push     (fifo_push),
        .push_dat ({inflight_last, bus.sram_rdata}),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );

    assign bus.cmd_ready  = (state == ST_IDLE);
    assign bus.sram_cen   = issue;
    assign bus.sram_wen   = 1'b0;
    assign bus.sram_addr  = cur_addr;
    assign bus.sram_wdata = '0;
    assign bus.sram_wstrb = {STRB_W{1'b0}};
    assign bus.rd_valid   = rd_vld;
    assign bus.rd_data    = !rd_vld ? '0 : (fifo_empty ? bus.sram_rdata : fifo_head[DW-1:0]);
    assign bus.rd_last    = !rd_vld ? 1'b0 : (fifo_empty ? inflight_last : fifo_head[DW]);
    assign bus.busy       = (state != ST_IDLE);
    assign bus.done       = finish;
endmodule

// File: tb/tb_sram_burst_reader.sv
// Directed bench for sram_burst_reader: table of bursts plus abort and reset sequences.
// Latency: n/a.
// Backpressure: rd_ready driven per table entry stall percentage.
module tb_sram_burst_reader;
    localparam int AW = 10;
    localparam int DW = 128;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_burst_reader_if #(.AW(AW), .DW(DW), .STRB_W(DW / 8)) bus_if ();

    sram_burst_reader #(
        .AW(AW), .DW(DW), .STRB_W(DW / 8), .FIFO_DEPTH(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // SRAM model: word at address a holds value a; data appears the cycle after cen.
    logic [DW-1:0] mem [1024];
    always @(posedge clk) begin
        if (bus_if.sram_cen) bus_if.sram_rdata <= mem[bus_if.sram_addr];
    end

    typedef struct {
        int addr;
        int len;
        int stall;
        int exp_beats;
        int exp_last_data;
        int exp_lat;
        int exp_span;
    } vec_t;

    vec_t vecs [5];

    int checks, errors, cyc;
    int issued, popped, max_out, stable_err;
    int accept_cyc, first_vld, last_pop, done_cyc, done_cnt, first_cen, last_cen, first_cen_addr;
    logic stalled_prev, prev_last;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] got_data [$];
    logic got_last [$];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, observe 1 ns later.
    task automatic cycle(input logic rdy, input logic ab, input logic cv);
        @(negedge clk);
        bus_if.rd_ready  = rdy;
        bus_if.abort     = ab;
        bus_if.cmd_valid = cv;
        #1;
        cyc++;
        if (issued - popped > max_out) max_out = issued - popped;
        if (stalled_prev && (!bus_if.rd_valid || bus_if.rd_data != prev_data ||
                             bus_if.rd_last != prev_last)) stable_err++;
        stalled_prev = bus_if.rd_valid && !rdy;
        prev_data    = bus_if.rd_data;
        prev_last    = bus_if.rd_last;
        if (cv && bus_if.cmd_ready) accept_cyc = cyc;
        if (bus_if.sram_cen) begin
            issued++;
            if (first_cen < 0) begin
                first_cen      = cyc;
                first_cen_addr = int'(bus_if.sram_addr);
            end
            last_cen = cyc;
        end
        if (bus_if.rd_valid && first_vld < 0) first_vld = cyc;
        if (bus_if.rd_valid && rdy) begin
            popped++;
            got_data.push_back(bus_if.rd_data);
            got_last.push_back(bus_if.rd_last);
            last_pop = cyc;
        end
        if (bus_if.done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
        end
    endtask

    task automatic start_cmd(input int addr, input int len);
        issued = 0; popped = 0; max_out = 0; stable_err = 0;
        accept_cyc = -1; first_vld = -1; last_pop = -1; done_cyc = -1; done_cnt = 0;
        first_cen = -1; last_cen = -1; first_cen_addr = -1;
        stalled_prev = 1'b0;
        got_data.delete();
        got_last.delete();
        bus_if.cmd_addr = AW'(addr);
        bus_if.cmd_len  = AW'(len);
        for (int t = 0; t < 8 && accept_cyc < 0; t++) cycle(1'b1, 1'b0, 1'b1);
    endtask

    task automatic run_burst(input int addr, input int len, input int stall);
        int budget;
        logic r;
        start_cmd(addr, len);
        budget = 4 * len + 64;
        for (int t = 0; t < budget && done_cyc < 0; t++) begin
            r = ($urandom_range(99) >= stall);
            cycle(r, 1'b0, 1'b0);
        end
        cycle(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int derr, lcnt, vld_seen;
        logic [DW-1:0] e;
        checks = 0; errors = 0; cyc = 0;
        for (int i = 0; i < 1024; i++) mem[i] = DW'(i);
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_addr  = '0;
        bus_if.cmd_len   = '0;
        bus_if.abort     = 1'b0;
        bus_if.rd_ready  = 1'b0;

        // Reset state
        #3;
        check("rst_cmd_ready", bus_if.cmd_ready, 1);
        check("rst_sram_cen",  bus_if.sram_cen, 0);
        check("rst_sram_wen",  bus_if.sram_wen, 0);
        check("rst_sram_addr", bus_if.sram_addr, 0);
        check("rst_rd_valid",  bus_if.rd_valid, 0);
        check("rst_rd_last",   bus_if.rd_last, 0);
        check("rst_rd_data",   (bus_if.rd_data == '0), 1);
        check("rst_busy",      bus_if.busy, 0);
        check("rst_done",      bus_if.done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        //          addr  len   stall beats last  lat span
        vecs[0] = '{5,    0,    0,    1,    5,    2,  0};
        vecs[1] = '{1020, 7,    0,    8,    3,    2,  7};
        vecs[2] = '{0,    1023, 0,    1024, 1023, 2,  1023};
        vecs[3] = '{200,  15,   30,   16,   215,  2,  -1};
        vecs[4] = '{1023, 1,    50,   2,    0,    2,  -1};

        for (int i = 0; i < 5; i++) begin
            run_burst(vecs[i].addr, vecs[i].len, vecs[i].stall);
            check($sformatf("v%0d_first_addr", i), first_cen_addr, vecs[i].addr);
            check($sformatf("v%0d_latency", i), first_vld - accept_cyc, vecs[i].exp_lat);
            check($sformatf("v%0d_beats", i), got_data.size(), vecs[i].exp_beats);
            check($sformatf("v%0d_reads", i), issued, vecs[i].exp_beats);
            derr = 0; lcnt = 0;
            foreach (got_data[k]) begin
                e = DW'((vecs[i].addr + k) % 1024);
                if (got_data[k] != e) derr++;
                if (got_last[k]) lcnt++;
            end
            check($sformatf("v%0d_data_errs", i), derr, 0);
            check($sformatf("v%0d_last_count", i), lcnt, 1);
            if (got_data.size() > 0) begin
                check($sformatf("v%0d_last_data", i), longint'(got_data[$]), vecs[i].exp_last_data);
                check($sformatf("v%0d_last_flag", i), got_last[$], 1);
            end
            check($sformatf("v%0d_done_cnt", i), done_cnt, 1);
            check($sformatf("v%0d_done_lat", i), done_cyc - last_pop, 1);
            check($sformatf("v%0d_out_le2", i), (max_out <= 2), 1);
            check($sformatf("v%0d_stable", i), stable_err, 0);
            check($sformatf("v%0d_busy_after", i), bus_if.busy, 0);
            check($sformatf("v%0d_ready_after", i), bus_if.cmd_ready, 1);
            if (vecs[i].exp_span >= 0) begin
                check($sformatf("v%0d_pop_span", i), last_pop - first_vld, vecs[i].exp_span);
                check($sformatf("v%0d_cen_span", i), last_cen - first_cen, vecs[i].exp_span);
            end
        end

        // Abort after 10 pops of a 64-beat burst
        start_cmd(400, 63);
        for (int t = 0; t < 40 && popped < 10; t++) cycle(1'b1, 1'b0, 1'b0);
        check("abort_pops_before", popped, 10);
        cycle(1'b1, 1'b1, 1'b0);
        check("abort_cen_same_cycle", bus_if.sram_cen, 0);
        derr = issued;
        cycle(1'b1, 1'b0, 1'b0);
        check("abort_rd_valid_next", bus_if.rd_valid, 0);
        check("abort_done_pulse", bus_if.done, 1);
        cycle(1'b1, 1'b0, 1'b0);
        check("abort_busy_after", bus_if.busy, 0);
        check("abort_done_low", bus_if.done, 0);
        check("abort_no_more_reads", issued, derr);
        run_burst(100, 0, 0);
        check("abort_next_beats", got_data.size(), 1);
        if (got_data.size() > 0) check("abort_next_data", longint'(got_data[0]), 100);

        // Reset in the middle of a 16-beat burst
        start_cmd(300, 15);
        for (int t = 0; t < 30 && popped < 4; t++) cycle(1'b1, 1'b0, 1'b0);
        check("rstmid_pops_before", popped, 4);
        check("rstmid_cen_before", bus_if.sram_cen, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rstmid_cen", bus_if.sram_cen, 0);
        check("rstmid_rd_valid", bus_if.rd_valid, 0);
        check("rstmid_busy", bus_if.busy, 0);
        check("rstmid_cmd_ready", bus_if.cmd_ready, 1);
        check("rstmid_sram_addr", bus_if.sram_addr, 0);
        cycle(1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        vld_seen = 0;
        for (int t = 0; t < 6; t++) begin
            cycle(1'b1, 1'b0, 1'b0);
            if (bus_if.rd_valid) vld_seen++;
        end
        check("rstmid_no_stale", vld_seen, 0);
        check("rstmid_ready_after", bus_if.cmd_ready, 1);
        run_burst(7, 0, 0);
        check("rstmid_next_beats", got_data.size(), 1);
        if (got_data.size() > 0) check("rstmid_next_data", longint'(got_data[0]), 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
